mem_stage: RTL and testbench

Memory stage of the multithreaded pipeline. Consumes the EX/MEM pipeline register outputs: resolves conditional branches, performs data-memory loads and stores through a ready-handshake port, and drives the registered MEM/WB outputs (write-back data, address, enable, thread). While a memory access is outstanding it raises `stall_out`, which upstream uses to drop `en` on the pipeline registers.

---
 rtl/mem_stage_pkg.sv | 24 ++
 rtl/mem_stage_if.sv | 26 ++
 rtl/mem_stage_dmem_access_fsm.sv | 107 ++++++++++
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions: memory-stage FSM encoding, default widths and
// the taken-branch equation also used by the hazard unit.
package arya_pipe_defs;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mem_state_t;

    localparam int DEF_DATAPATH_WIDTH     = 64;
    localparam int DEF_REGFILE_ADDR_WIDTH = 5;
    localparam int DEF_INST_ADDR_WIDTH    = 9;
    localparam int DEF_THREAD_BITS        = 2;
    localparam int DEF_DMEM_ADDR_WIDTH    = 8;
    localparam int DEF_DMEM_TIMEOUT       = 15;

    // Wide enough for any DMEM_TIMEOUT in 1..15.
    localparam int WAIT_CNT_W = 4;

    function automatic logic branch_taken(input logic beq, input logic bneq, input logic zero);
        return (beq & zero) | (bneq & ~zero);
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Data-memory port with ready handshake; the pipeline side is the master.
interface mem_stage_if
    import arya_pipe_defs::*;
#(
    parameter int DATA_W = DEF_DATAPATH_WIDTH,
    parameter int ADDR_W = DEF_DMEM_ADDR_WIDTH
) ();

    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [DATA_W-1:0] dmem_wdata;
    logic              dmem_ready;
    logic [DATA_W-1:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  dmem_ready, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output dmem_ready, dmem_rdata
    );

endinterface

// File: rtl/mem_stage_dmem_access_fsm.sv
// Data-memory access sequencer: state register, wait counter, registered
// dmem port and the combinational upstream stall.
//
//   state | meaning
//   IDLE  | no access outstanding; a mem_op is captured on the next edge
//   BUSY  | request on the port, waiting for dmem_ready or the timeout
module dmem_access_fsm
    import arya_pipe_defs::*;
#(
    parameter int DATAPATH_WIDTH  = DEF_DATAPATH_WIDTH,
    parameter int DMEM_ADDR_WIDTH = DEF_DMEM_ADDR_WIDTH,
    parameter int DMEM_TIMEOUT    = DEF_DMEM_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       mem_op,
    input  logic                       is_store,
    input  logic [DMEM_ADDR_WIDTH-1:0] addr,
    input  logic [DATAPATH_WIDTH-1:0]  wdata,
    mem_stage_if.master                dmem,
    output logic                       stall,
    output logic                       capture,
    output logic                       complete,
    output logic                       timeout_err,
    output logic                       busy
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_CNT = WAIT_CNT_W'(DMEM_TIMEOUT - 1);

    mem_state_t                 state, state_next;
    logic [WAIT_CNT_W-1:0]      cnt, cnt_next;
    logic                       req_q, req_next;
    logic                       we_q, we_next;
    logic [DMEM_ADDR_WIDTH-1:0] addr_q, addr_next;
    logic [DATAPATH_WIDTH-1:0]  wdata_q, wdata_next;
    logic                       timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            req_q   <= req_next;
            we_q    <= we_next;
            addr_q  <= addr_next;
            wdata_q <= wdata_next;
        end
    end

    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        req_next    = req_q;
        we_next     = we_q;
        addr_next   = addr_q;
        wdata_next  = wdata_q;
        stall       = 1'b0;
        capture     = 1'b0;
        complete    = 1'b0;
        timeout_err = 1'b0;
        timeout     = (cnt == TIMEOUT_CNT);
        case (state)
            IDLE: begin
                if (mem_op) begin
                    stall      = 1'b1;
                    capture    = 1'b1;
                    state_next = BUSY;
                    cnt_next   = '0;
                    req_next   = 1'b1;
                    we_next    = is_store;
                    addr_next  = addr;
                    wdata_next = wdata;
                end
            end
            BUSY: begin
                // Ready wins over a timeout landing in the same cycle.
                stall = ~dmem.dmem_ready & ~timeout;
                if (dmem.dmem_ready) begin
                    complete   = 1'b1;
                    state_next = IDLE;
                    req_next   = 1'b0;
                    we_next    = 1'b0;
                end else if (timeout) begin
                    timeout_err = 1'b1;
                    state_next  = IDLE;
                    req_next    = 1'b0;
                    we_next     = 1'b0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
        endcase
    end

    assign busy            = (state == BUSY);
    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_wdata = wdata_q;

endmodule

// File: rtl/mem_stage.sv
// Memory stage: branch resolution, data-memory access sequencing and the
// registered MEM/WB and branch-redirect outputs.
module mem_stage
    import arya_pipe_defs::*;
#(
    parameter int DATAPATH_WIDTH     = DEF_DATAPATH_WIDTH,
    parameter int REGFILE_ADDR_WIDTH = DEF_REGFILE_ADDR_WIDTH,
    parameter int INST_ADDR_WIDTH    = DEF_INST_ADDR_WIDTH,
    parameter int THREAD_BITS        = DEF_THREAD_BITS,
    parameter int DMEM_ADDR_WIDTH    = DEF_DMEM_ADDR_WIDTH,
    parameter int DMEM_TIMEOUT       = DEF_DMEM_TIMEOUT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [INST_ADDR_WIDTH-1:0]    branch_target_in,
    input  logic [DATAPATH_WIDTH-1:0]     accum_in,
    input  logic [DATAPATH_WIDTH-1:0]     store_data_in,
    input  logic [REGFILE_ADDR_WIDTH-1:0] WR_addr_in,
    input  logic                          WR_en_in,
    input  logic                          beq_in,
    input  logic                          bneq_in,
    input  logic                          mem_write_in,
    input  logic                          zero_in,
    input  logic                          mem_reg_sel_in,
    input  logic [THREAD_BITS-1:0]        thread_id_in,
    mem_stage_if.master                   dmem,
    output logic                          stall_out,
    output logic [DATAPATH_WIDTH-1:0]     wb_data_out,
    output logic [REGFILE_ADDR_WIDTH-1:0] wb_addr_out,
    output logic                          wb_en_out,
    output logic [THREAD_BITS-1:0]        wb_thread_id_out,
    output logic                          pc_load_out,
    output logic [INST_ADDR_WIDTH-1:0]    pc_target_out,
    output logic [THREAD_BITS-1:0]        pc_thread_out,
    output logic                          mem_error_out
);

    logic                          mem_op;
    logic                          taken;
    logic                          capture;
    logic                          complete;
    logic                          timeout_err;
    logic                          busy;
    logic [REGFILE_ADDR_WIDTH-1:0] lat_addr;
    logic                          lat_en;
    logic                          lat_load;
    logic [THREAD_BITS-1:0]        lat_thread;

    assign mem_op = mem_write_in | mem_reg_sel_in;
    assign taken  = branch_taken(beq_in, bneq_in, zero_in);

    dmem_access_fsm #(
        .DATAPATH_WIDTH  (DATAPATH_WIDTH),
        .DMEM_ADDR_WIDTH (DMEM_ADDR_WIDTH),
        .DMEM_TIMEOUT    (DMEM_TIMEOUT)
    ) u_fsm (
        .clk         (clk),
        .reset       (reset),
        .mem_op      (mem_op),
        .is_store    (mem_write_in),
        .addr        (accum_in[DMEM_ADDR_WIDTH-1:0]),
        .wdata       (store_data_in),
        .dmem        (dmem),
        .stall       (stall_out),
        .capture     (capture),
        .complete    (complete),
        .timeout_err (timeout_err),
        .busy        (busy)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_data_out      <= '0;
            wb_addr_out      <= '0;
            wb_en_out        <= 1'b0;
            wb_thread_id_out <= '0;
            pc_load_out      <= 1'b0;
            pc_target_out    <= '0;
            pc_thread_out    <= '0;
            mem_error_out    <= 1'b0;
            lat_addr         <= '0;
            lat_en           <= 1'b0;
            lat_load         <= 1'b0;
            lat_thread       <= '0;
        end else begin
            pc_load_out   <= 1'b0;
            mem_error_out <= 1'b0;
            if (capture) begin
                // A branch flagged together with a mem_op is dropped.
                lat_addr   <= WR_addr_in;
                lat_en     <= WR_en_in;
                lat_load   <= ~mem_write_in;
                lat_thread <= thread_id_in;
                wb_en_out  <= 1'b0;
            end else if (complete) begin
                wb_addr_out      <= lat_addr;
                wb_thread_id_out <= lat_thread;
                wb_en_out        <= lat_load & lat_en;
                if (lat_load) begin
                    wb_data_out <= dmem.dmem_rdata;
                end
            end else if (timeout_err) begin
                wb_addr_out      <= lat_addr;
                wb_thread_id_out <= lat_thread;
                wb_en_out        <= 1'b0;
                mem_error_out    <= 1'b1;
            end else if (!busy) begin
                wb_data_out      <= accum_in;
                wb_addr_out      <= WR_addr_in;
                wb_en_out        <= WR_en_in;
                wb_thread_id_out <= thread_id_in;
                pc_load_out      <= taken;
                pc_target_out    <= branch_target_in;
                pc_thread_out    <= thread_id_in;
            end else begin
                wb_en_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: table of ALU/branch vectors, directed
// memory sequences and a randomized mix against a cycle-count reference model.
module tb_mem_stage;

    localparam int T = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [8:0]  branch_target_in;
    logic [63:0] accum_in;
    logic [63:0] store_data_in;
    logic [4:0]  WR_addr_in;
    logic        WR_en_in, beq_in, bneq_in, mem_write_in, zero_in, mem_reg_sel_in;
    logic [1:0]  thread_id_in;
    logic        stall_out;
    logic [63:0] wb_data_out;
    logic [4:0]  wb_addr_out;
    logic        wb_en_out;
    logic [1:0]  wb_thread_id_out;
    logic        pc_load_out;
    logic [8:0]  pc_target_out;
    logic [1:0]  pc_thread_out;
    logic        mem_error_out;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage_if #(.DATA_W(64), .ADDR_W(8)) dmem_bus ();

    mem_stage #(
        .DATAPATH_WIDTH(64), .REGFILE_ADDR_WIDTH(5), .INST_ADDR_WIDTH(9),
        .THREAD_BITS(2), .DMEM_ADDR_WIDTH(8), .DMEM_TIMEOUT(T)
    ) dut (
        .clk(clk), .reset(reset),
        .branch_target_in(branch_target_in), .accum_in(accum_in),
        .store_data_in(store_data_in), .WR_addr_in(WR_addr_in), .WR_en_in(WR_en_in),
        .beq_in(beq_in), .bneq_in(bneq_in), .mem_write_in(mem_write_in),
        .zero_in(zero_in), .mem_reg_sel_in(mem_reg_sel_in), .thread_id_in(thread_id_in),
        .dmem(dmem_bus), .stall_out(stall_out),
        .wb_data_out(wb_data_out), .wb_addr_out(wb_addr_out), .wb_en_out(wb_en_out),
        .wb_thread_id_out(wb_thread_id_out), .pc_load_out(pc_load_out),
        .pc_target_out(pc_target_out), .pc_thread_out(pc_thread_out),
        .mem_error_out(mem_error_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] acc;
        logic [4:0]  wa;
        logic        wen;
        logic [1:0]  th;
        logic        beq;
        logic        bneq;
        logic        zero;
        logic [8:0]  tgt;
        logic        exp_pc;
    } alu_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_nop();
        branch_target_in = '0; accum_in = '0; store_data_in = '0; WR_addr_in = '0;
        WR_en_in = 0; beq_in = 0; bneq_in = 0; mem_write_in = 0; zero_in = 0;
        mem_reg_sel_in = 0; thread_id_in = '0;
        dmem_bus.dmem_ready = 0; dmem_bus.dmem_rdata = '0;
    endtask

    // Non-memory instruction: wb_* mirror the inputs, pc_load is the branch outcome.
    task automatic alu_op(input alu_vec_t v);
        accum_in = v.acc; WR_addr_in = v.wa; WR_en_in = v.wen; thread_id_in = v.th;
        beq_in = v.beq; bneq_in = v.bneq; zero_in = v.zero; branch_target_in = v.tgt;
        mem_write_in = 0; mem_reg_sel_in = 0; store_data_in = {$urandom, $urandom};
        dmem_bus.dmem_ready = 1'($urandom_range(0, 1));
        dmem_bus.dmem_rdata = {$urandom, $urandom};
        #1;
        chk("alu_stall", stall_out, 0);
        tick();
        chk("alu_wb_data", wb_data_out, v.acc);
        chk("alu_wb_addr", wb_addr_out, v.wa);
        chk("alu_wb_en", wb_en_out, v.wen);
        chk("alu_wb_thread", wb_thread_id_out, v.th);
        chk("alu_pc_load", pc_load_out, v.exp_pc);
        if (v.exp_pc) begin
            chk("alu_pc_target", pc_target_out, v.tgt);
            chk("alu_pc_thread", pc_thread_out, v.th);
        end
        chk("alu_req_idle", dmem_bus.dmem_req, 0);
        chk("alu_mem_error", mem_error_out, 0);
        dmem_bus.dmem_ready = 0;
    endtask

    // Memory op; ready is raised in BUSY cycle index 'waits' (0-based).
    task automatic run_mem(input bit store, input logic [63:0] acc, input logic [63:0] sd,
                           input logic [4:0] wa, input bit wen, input logic [1:0] th,
                           input int waits, input logic [63:0] rd, input bit br);
        int  busy_cnt, stall_cnt, we_cnt, addr_bad, exp_busy;
        bit  done, tmo;
        tmo      = (waits >= T);
        exp_busy = tmo ? T : waits + 1;
        accum_in = acc; store_data_in = sd; WR_addr_in = wa; WR_en_in = wen;
        thread_id_in = th; mem_write_in = store; mem_reg_sel_in = !store;
        beq_in = br; zero_in = br; bneq_in = 0; branch_target_in = 9'h0FF;
        dmem_bus.dmem_ready = 0;
        #1;
        chk("cap_stall", stall_out, 1);
        stall_cnt = stall_out ? 1 : 0;
        tick();
        chk("req_rise", dmem_bus.dmem_req, 1);
        chk("req_addr", dmem_bus.dmem_addr, {56'd0, acc[7:0]});
        chk("req_we", dmem_bus.dmem_we, store);
        if (store) chk("req_wdata", dmem_bus.dmem_wdata, sd);
        chk("memop_pc_load", pc_load_out, 0);
        chk("capture_wb_en", wb_en_out, 0);
        busy_cnt = 0; we_cnt = 0; addr_bad = 0; done = 0;
        for (int c = 0; c < T + 4 && !done; c++) begin
            busy_cnt++;
            if (dmem_bus.dmem_we) we_cnt++;
            if (dmem_bus.dmem_addr !== acc[7:0]) addr_bad++;
            dmem_bus.dmem_ready = (c == waits);
            dmem_bus.dmem_rdata = (c == waits) ? rd : {$urandom, $urandom};
            #1;
            if (stall_out) stall_cnt++;
            tick();
            dmem_bus.dmem_ready = 0;
            if (!dmem_bus.dmem_req) done = 1;
        end
        chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
        chk("stall_cycles", 64'(stall_cnt), 64'(exp_busy));
        chk("we_cycles", 64'(we_cnt), store ? 64'(exp_busy) : 64'd0);
        chk("addr_stable", 64'(addr_bad), 64'd0);
        chk("done_mem_error", mem_error_out, tmo);
        chk("done_wb_en", wb_en_out, !tmo && !store && wen);
        chk("done_wb_thread", wb_thread_id_out, th);
        chk("done_we_low", dmem_bus.dmem_we, 0);
        if (!tmo && !store) begin
            chk("load_wb_data", wb_data_out, rd);
            chk("load_wb_addr", wb_addr_out, wa);
        end
        set_nop();
    endtask

    alu_vec_t vecs[6];
    alu_vec_t nopv;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'h1234, 5'd7,  1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 9'h000, 1'b0};
        vecs[1] = '{64'h0,    5'd0,  1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 9'h1A5, 1'b1};
        vecs[2] = '{64'h5,    5'd1,  1'b0, 2'd3, 1'b0, 1'b1, 1'b1, 9'h1A5, 1'b0};
        vecs[3] = '{64'hFFFF_0000_AAAA_5555, 5'd31, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, 9'h0C3, 1'b1};
        vecs[4] = '{64'h77,   5'd12, 1'b1, 2'd0, 1'b1, 1'b0, 1'b0, 9'h011, 1'b0};
        vecs[5] = '{64'h99,   5'd2,  1'b0, 2'd2, 1'b1, 1'b1, 1'b0, 9'h1FF, 1'b1};
        nopv    = '{64'h0, 5'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 9'h0, 1'b0};

        set_nop();
        reset = 1;
        tick(); tick();
        chk("rst_req", dmem_bus.dmem_req, 0);
        chk("rst_we", dmem_bus.dmem_we, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_wb", {wb_data_out, wb_addr_out, wb_en_out, wb_thread_id_out} == '0, 1);
        chk("rst_pc", {pc_load_out, pc_target_out, pc_thread_out, mem_error_out} == '0, 1);
        reset = 0;

        for (int i = 0; i < 6; i++) alu_op(vecs[i]);

        run_mem(0, 64'h42, 64'h0, 5'd9, 1, 2'd1, 3, 64'hDEAD_BEEF, 0);
        alu_op(nopv);
        run_mem(1, 64'h10, 64'h55, 5'd4, 1, 2'd2, 0, 64'h0, 0);
        alu_op(nopv);
        run_mem(0, 64'h80, 64'h0, 5'd3, 1, 2'd3, T + 2, 64'h0, 0);
        alu_op(nopv);
        run_mem(0, 64'h1FE, 64'h0, 5'd6, 1, 2'd0, T - 1, 64'hCAFE_F00D, 1);
        alu_op(nopv);

        // Reset in the second BUSY cycle of a store.
        accum_in = 64'h33; store_data_in = 64'hABCD; mem_write_in = 1;
        WR_addr_in = 5'd5; thread_id_in = 2'd1;
        tick();
        tick();
        reset = 1;
        set_nop();
        tick();
        chk("midrst_req", dmem_bus.dmem_req, 0);
        chk("midrst_stall", stall_out, 0);
        chk("midrst_port", {dmem_bus.dmem_we, dmem_bus.dmem_addr, dmem_bus.dmem_wdata} == '0, 1);
        chk("midrst_wb", {wb_data_out, wb_addr_out, wb_en_out, wb_thread_id_out} == '0, 1);
        chk("midrst_pc", {pc_load_out, pc_target_out, pc_thread_out, mem_error_out} == '0, 1);
        reset = 0;
        dmem_bus.dmem_ready = 1;
        dmem_bus.dmem_rdata = 64'h1111;
        #1;
        chk("late_ready_stall", stall_out, 0);
        tick();
        chk("late_ready_req", dmem_bus.dmem_req, 0);
        chk("late_ready_wb_en", wb_en_out, 0);
        chk("late_ready_wb_data", wb_data_out, 0);
        set_nop();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                alu_vec_t v;
                v.acc = {$urandom, $urandom}; v.wa = 5'($urandom); v.wen = 1'($urandom);
                v.th = 2'($urandom); v.beq = 1'($urandom); v.bneq = 1'($urandom);
                v.zero = 1'($urandom); v.tgt = 9'($urandom);
                v.exp_pc = (v.beq && v.zero) || (v.bneq && !v.zero);
                alu_op(v);
            end else begin
                run_mem(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                        5'($urandom), 1'($urandom), 2'($urandom),
                        $urandom_range(0, T + 2), {$urandom, $urandom}, 1'($urandom));
            end
        end
        alu_op(nopv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
